program_loader: RTL and testbench

Byte-stream writer for the picoMIPS program memory. It receives a length-prefixed stream of 8-bit bytes and assembles I_SIZE-bit instructions most-significant byte first. Each instruction is written into the writable program memory at consecutive addresses starting from 0. While loading, the loader holds the CPU (program counter and registers) in reset, and it releases the CPU once the image is complete and valid.

---
 rtl/program_loader.sv | 178 +++++++++++++++++
 tb/tb_program_loader.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// picoMIPS program-memory loader: length-prefixed byte stream -> I_SIZE-bit words, MSB byte first.
// Optional trailing checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
module program_loader #(
  parameter int unsigned P_SIZE = 6,
  parameter int unsigned I_SIZE = 24
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic [7:0]        byteData,
  input  logic              byteValid,
  output logic              byteReady,
  input  logic              reload,
  output logic              wrEn,
  output logic [P_SIZE-1:0] wrAddr,
  output logic [I_SIZE-1:0] wrData,
  output logic              cpuHold,
  output logic              done,
  output logic              error
);

  localparam int unsigned B  = I_SIZE / 8;
  localparam int unsigned BW = (B > 1) ? $clog2(B) : 1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_HEADER, ST_DATA, ST_WRITE, ST_CHECK, ST_DONE, ST_ERROR
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_HEADER, ST_DATA, ST_WRITE, ST_DONE, ST_ERROR
  } state_t;
`endif

  state_t              r_state;
  logic                r_byteReady;
  logic                r_wrEn;
  logic [P_SIZE-1:0]   r_wrAddr;
  logic [P_SIZE-1:0]   r_lastAddr;
  logic [BW-1:0]       r_byteIdx;
  logic [I_SIZE-1:0]   r_asm;
  logic                r_cpuHold;
  logic                r_done;
  logic                r_error;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]          r_sum;
`endif

  logic                w_xfer;
  logic [P_SIZE+7:0]   w_hdrExt;
  logic                w_hdrBad;
  logic [I_SIZE-1:0]   w_asmNext;

  assign w_xfer    = byteValid && r_byteReady;
  // Header bits at or above P_SIZE must be zero; for P_SIZE >= 8 the shift leaves nothing.
  assign w_hdrExt  = {{P_SIZE{1'b0}}, byteData};
  assign w_hdrBad  = (w_hdrExt >> P_SIZE) != '0;
  assign w_asmNext = (r_asm << 8) | I_SIZE'(byteData);

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state     <= ST_HEADER;
      r_byteReady <= 1'b1;
      r_wrEn      <= 1'b0;
      r_wrAddr    <= '0;
      r_lastAddr  <= '0;
      r_byteIdx   <= '0;
      r_asm       <= '0;
      r_cpuHold   <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      case (r_state)
        ST_HEADER: begin
          if (w_xfer) begin
            if (w_hdrBad) begin
              r_state     <= ST_ERROR;
              r_byteReady <= 1'b0;
              r_error     <= 1'b1;
            end else begin
              r_state    <= ST_DATA;
              r_lastAddr <= w_hdrExt[P_SIZE-1:0];
              r_byteIdx  <= '0;
              r_wrAddr   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
              r_sum      <= '0;
`endif
            end
          end
        end

        ST_DATA: begin
          if (w_xfer) begin
            r_asm <= w_asmNext;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum <= r_sum + byteData;
`endif
            if (r_byteIdx == BW'(B - 1)) begin
              r_state     <= ST_WRITE;
              r_byteReady <= 1'b0;
              r_wrEn      <= 1'b1;
            end else begin
              r_byteIdx <= r_byteIdx + BW'(1);
            end
          end
        end

        ST_WRITE: begin
          r_wrEn    <= 1'b0;
          r_wrAddr  <= r_wrAddr + P_SIZE'(1);
          r_byteIdx <= '0;
          if (r_wrAddr == r_lastAddr) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_state     <= ST_CHECK;
            r_byteReady <= 1'b1;
`else
            r_state     <= ST_DONE;
            r_done      <= 1'b1;
            r_cpuHold   <= 1'b0;
`endif
          end else begin
            r_state     <= ST_DATA;
            r_byteReady <= 1'b1;
          end
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        ST_CHECK: begin
          if (w_xfer) begin
            r_byteReady <= 1'b0;
            if (byteData == r_sum) begin
              r_state   <= ST_DONE;
              r_done    <= 1'b1;
              r_cpuHold <= 1'b0;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif

        ST_DONE, ST_ERROR: begin
          if (reload) begin
            r_state     <= ST_HEADER;
            r_byteReady <= 1'b1;
            r_cpuHold   <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
          end
        end

        default: begin
          r_state     <= ST_HEADER;
          r_byteReady <= 1'b1;
          r_wrEn      <= 1'b0;
          r_cpuHold   <= 1'b1;
          r_done      <= 1'b0;
          r_error     <= 1'b0;
        end
      endcase
    end
  end

  assign byteReady = r_byteReady;
  assign wrEn      = r_wrEn;
  assign wrAddr    = r_wrAddr;
  assign wrData    = r_asm;
  assign cpuHold   = r_cpuHold;
  assign done      = r_done;
  assign error     = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table vectors, timing sequences, randomized loads vs. a stream model.
module tb_program_loader;

  localparam int unsigned P_SIZE = 6;
  localparam int unsigned I_SIZE = 24;

  logic              clk = 1'b0;
  logic              nRst = 1'b0;
  logic [7:0]        byteData = '0;
  logic              byteValid = 1'b0;
  logic              byteReady;
  logic              reload = 1'b0;
  logic              wrEn;
  logic [P_SIZE-1:0] wrAddr;
  logic [I_SIZE-1:0] wrData;
  logic              cpuHold;
  logic              done;
  logic              error;

  program_loader #(.P_SIZE(P_SIZE), .I_SIZE(I_SIZE)) dut (
    .clk(clk), .nRst(nRst), .byteData(byteData), .byteValid(byteValid),
    .byteReady(byteReady), .reload(reload), .wrEn(wrEn), .wrAddr(wrAddr),
    .wrData(wrData), .cpuHold(cpuHold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [P_SIZE-1:0] a;
    logic [I_SIZE-1:0] d;
    int                c;
  } wr_t;

  wr_t        got_q[$];
  wr_t        exp_q[$];
  logic [7:0] stim_q[$];
  bit         noise = 1'b0;
  int unsigned gap_max = 0;
  int         done_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (nRst && wrEn) begin
      got_q.push_back('{wrAddr, wrData, cyc});
      chk("ready_low_in_write", {63'b0, byteReady}, 64'd0);
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int unsigned g;
    int guard;
    logic rdy;
    g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
    for (int i = 0; i < int'(g); i++) begin
      @(negedge clk);
      byteValid = 1'b0;
      reload = noise && ($urandom_range(0, 3) == 0);
      @(posedge clk);
    end
    @(negedge clk);
    byteData  = b;
    byteValid = 1'b1;
    reload = noise && ($urandom_range(0, 3) == 0);
    guard = 0;
    forever begin
      rdy = byteReady;
      @(posedge clk);
      if (rdy) break;
      guard++;
      if (guard > 100) begin
        checks++;
        failures++;
        $display("FAIL accept_timeout byte=%0h not taken within 100 cycles", b);
        break;
      end
      @(negedge clk);
      reload = noise && ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    byteValid = 1'b0;
    reload    = 1'b0;
  endtask

  task automatic wait_end();
    int n;
    n = 0;
    while (!(done || error) && n < 300) begin
      @(negedge clk);
      n++;
    end
    done_cyc = cyc;
    if (!(done || error)) begin
      checks++;
      failures++;
      $display("FAIL end_timeout done=%0b error=%0b after %0d cycles", done, error, n);
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
    chk("reload_ready", {63'b0, byteReady}, 64'd1);
    chk("reload_done", {63'b0, done}, 64'd0);
    chk("reload_error", {63'b0, error}, 64'd0);
    chk("reload_hold", {63'b0, cpuHold}, 64'd1);
  endtask

  // Reference: count = hdr+1 words, word i = bytes 3i..3i+2 MSB first, at address i.
  task automatic model(input logic [7:0] hdr, output bit herr);
    exp_q.delete();
    herr = (hdr >= 8'd64);
    if (!herr) begin
      for (int i = 0; i <= int'(hdr); i++)
        exp_q.push_back('{P_SIZE'(i), {stim_q[3*i], stim_q[3*i+1], stim_q[3*i+2]}, 0});
    end
  endtask

  task automatic run_load(input logic [7:0] hdr, input logic [7:0] csum_xor);
    bit herr;
    bit exp_err;
    logic [7:0] s;
    int n;
    got_q.delete();
    model(hdr, herr);
    exp_err = herr;
    send_byte(hdr);
    if (!herr) begin
      s = '0;
      foreach (stim_q[i]) begin
        send_byte(stim_q[i]);
        s = s + stim_q[i];
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      send_byte(s ^ csum_xor);
      exp_err = (csum_xor != 0);
`else
      if (csum_xor != 0) $display("note: checksum byte not part of this build");
`endif
    end
    idle();
    wait_end();
    chk("nwrites", 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk("wr_addr", 64'(got_q[i].a), 64'(exp_q[i].a));
      chk("wr_data", 64'(got_q[i].d), 64'(exp_q[i].d));
    end
    chk("end_done", {63'b0, done}, {63'b0, !exp_err});
    chk("end_error", {63'b0, error}, {63'b0, exp_err});
    chk("end_hold", {63'b0, cpuHold}, {63'b0, exp_err});
  endtask

  typedef struct {
    logic [7:0]        hdr;
    logic [I_SIZE-1:0] w0;
    logic [I_SIZE-1:0] w1;
    logic              exp_err;
    int unsigned       exp_n;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{8'h00, 24'h123456, 24'h000000, 1'b0, 1};
    tbl[1] = '{8'h01, 24'hA5C3F0, 24'h0F1E2D, 1'b0, 2};
    tbl[2] = '{8'h40, 24'h000000, 24'h000000, 1'b1, 0};
    tbl[3] = '{8'hFF, 24'h000000, 24'h000000, 1'b1, 0};
    tbl[4] = '{8'h80, 24'h000000, 24'h000000, 1'b1, 0};

    repeat (2) @(negedge clk);
    nRst = 1'b1;
    chk("rst_ready", {63'b0, byteReady}, 64'd1);
    chk("rst_wren", {63'b0, wrEn}, 64'd0);
    chk("rst_addr", 64'(wrAddr), 64'd0);
    chk("rst_data", 64'(wrData), 64'd0);
    chk("rst_hold", {63'b0, cpuHold}, 64'd1);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_error", {63'b0, error}, 64'd0);

    // Back-to-back two-word load: write spacing and done latency.
    stim_q = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    run_load(8'h01, 8'h00);
    if (got_q.size() == 2) begin
      chk("w0_data", 64'(got_q[0].d), 64'h123456);
      chk("w1_data", 64'(got_q[1].d), 64'hABCDEF);
      chk("write_spacing", 64'(got_q[1].c - got_q[0].c), 64'd4);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      chk("done_latency", 64'(done_cyc - got_q[1].c), 64'd1);
`endif
    end

    foreach (tbl[t]) begin
      do_reload();
      stim_q.delete();
      for (int k = 2; k >= 0; k--) stim_q.push_back(tbl[t].w0[8*k +: 8]);
      if (tbl[t].hdr == 8'h01)
        for (int k = 2; k >= 0; k--) stim_q.push_back(tbl[t].w1[8*k +: 8]);
      run_load(tbl[t].hdr, 8'h00);
      chk("tbl_n", 64'(got_q.size()), 64'(tbl[t].exp_n));
      chk("tbl_err", {63'b0, error}, {63'b0, tbl[t].exp_err});
      if (got_q.size() >= 1) chk("tbl_w0", 64'(got_q[0].d), 64'(tbl[t].w0));
      if (got_q.size() == 2) chk("tbl_w1", 64'(got_q[1].d), 64'(tbl[t].w1));
    end

    // Full-capacity image.
    do_reload();
    stim_q.delete();
    for (int i = 0; i < 192; i++) stim_q.push_back(8'($urandom));
    run_load(8'h3F, 8'h00);
    if (got_q.size() == 64) chk("full_last_addr", 64'(got_q[63].a), 64'd63);

    // Random gaps and reload noise while loading.
    noise = 1'b1;
    gap_max = 3;
    for (int r = 0; r < 15; r++) begin
      int unsigned h;
      do_reload();
      h = $urandom_range(0, 12);
      stim_q.delete();
      for (int i = 0; i < 3 * (int'(h) + 1); i++) stim_q.push_back(8'($urandom));
      run_load(8'(h), 8'h00);
    end
    noise = 1'b0;
    gap_max = 0;

    // Reset after two bytes of the second instruction.
    do_reload();
    send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    send_byte(8'h44); send_byte(8'h55);
    idle();
    #2 nRst = 1'b0;
    #1;
    chk("midrst_wren", {63'b0, wrEn}, 64'd0);
    chk("midrst_addr", 64'(wrAddr), 64'd0);
    chk("midrst_hold", {63'b0, cpuHold}, 64'd1);
    @(negedge clk);
    nRst = 1'b1;
    stim_q = '{8'h9A, 8'hBC, 8'hDE, 8'h01, 8'h23, 8'h45};
    run_load(8'h01, 8'h00);

    // Reset landing in a write cycle drops the strobe at once.
    do_reload();
    send_byte(8'h00);
    send_byte(8'h77); send_byte(8'h88); send_byte(8'h99);
    idle();
    chk("pre_rst_wren", {63'b0, wrEn}, 64'd1);
    #2 nRst = 1'b0;
    #1;
    chk("wrrst_wren", {63'b0, wrEn}, 64'd0);
    chk("wrrst_hold", {63'b0, cpuHold}, 64'd1);
    @(negedge clk);
    nRst = 1'b1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    stim_q = '{8'h01, 8'h02, 8'h03};
    run_load(8'h00, 8'h00);
    do_reload();
    run_load(8'h00, 8'h01);
    do_reload();
    run_load(8'h00, 8'h00);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
